// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU built-in self-test.
//   - ALU control codes driven onto alu_ctrl
//   - op table that fixes the order in which the BIST walks the opcodes
//   - FSM state type
//   - golden reference model of the ALU
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_ILL   = 4'b1111;

    localparam int N_OPS = 6;

    // Entry 0 is the first op exercised by a run.
    localparam logic [N_OPS-1:0][3:0] OP_TABLE =
        {ALU_ILL, ALU_PASSB, ALU_SUB, ALU_ADD, ALU_ORR, ALU_AND};

    // Mask that decorrelates operand B from operand A on random vectors.
    localparam logic [63:0] B_MIX = 64'hA5A5_A5A5_A5A5_A5A5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Reference behaviour of the ALU; unknown/illegal codes produce 0.
    function automatic logic [63:0] alu_golden(input logic [3:0]  ctrl,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
        logic [63:0] r;
        case (ctrl)
            ALU_AND:   r = a & b;
            ALU_ORR:   r = a | b;
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bist_lfsr64.sv
// ---------------------------------------------------------------------------
// lfsr64
// 64-bit Fibonacci LFSR, taps 64,63,61,60 (shift left, feedback into bit 0).
// Ports:
//   clk    in   1   clock
//   reset  in   1   asynchronous active-high, loads RESET_VALUE
//   load   in   1   load seed (priority over en)
//   en     in   1   advance one step
//   seed   in   64  value loaded when load=1
//   q      out  64  current LFSR state
// ---------------------------------------------------------------------------
module lfsr64 #(
    parameter logic [63:0] RESET_VALUE = 64'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [63:0] seed,
    output logic [63:0] q
);

    logic [63:0] q_reg;
    logic        feedback;

    assign feedback = q_reg[63] ^ q_reg[62] ^ q_reg[60] ^ q_reg[59];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= RESET_VALUE;
        end else if (load) begin
            q_reg <= seed;
        end else if (en) begin
            q_reg <= {q_reg[62:0], feedback};
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/alu_bist.sv
// ---------------------------------------------------------------------------
// alu_bist
// Built-in self-test initiator for the 64-bit datapath ALU. Walks six opcodes,
// N_VECTORS vectors each (4 fixed corners then LFSR-driven vectors), one vector
// per cycle, and checks alu_result/alu_zero one cycle after each vector is
// registered against the golden model.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   start                           level; launches a run from IDLE, or from
//                                   DONE on a fresh rising edge
//   alu_a/alu_b/alu_ctrl    out     registered vector driven into the ALU
//   alu_result/alu_zero     in      ALU response to the registered vector
//   busy/done/pass          out     run status
//   err_count               out     mismatching vectors (saturating)
//   fail_ctrl/a/b/result    out     first mismatching vector and its result
// ---------------------------------------------------------------------------
module alu_bist
    import alu_pkg::*;
#(
    parameter int          N_VECTORS = 256,
    parameter logic [63:0] SEED      = 64'hACE1_0F0F_1234_5678
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [3:0]  fail_ctrl,
    output logic [63:0] fail_a,
    output logic [63:0] fail_b,
    output logic [63:0] fail_result
);

    localparam int               IDX_W   = $clog2(N_VECTORS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_VECTORS - 1);
    localparam logic [2:0]       OP_MAX  = 3'(N_OPS - 1);

    bist_state_t state_reg, state_next;

    logic             start_d_reg;
    // Pointer to the vector that will be registered on the next RUN edge.
    logic [2:0]       ptr_op_reg;
    logic [IDX_W-1:0] ptr_idx_reg;
    // Set once the final vector has been registered; its check ends the run.
    logic             last_reg;

    logic [63:0] alu_a_reg, alu_b_reg;
    logic [3:0]  alu_ctrl_reg;
    logic [15:0] err_count_reg;
    logic [3:0]  fail_ctrl_reg;
    logic [63:0] fail_a_reg, fail_b_reg, fail_result_reg;

    logic             launch;
    logic             advance;
    logic [2:0]       gen_op;
    logic [IDX_W-1:0] gen_idx;
    logic [3:0]       gen_ctrl;
    logic [63:0]      gen_a, gen_b;
    logic [63:0]      lfsr_q;
    logic [63:0]      expected;
    logic             mismatch;

    // From DONE only a fresh rising edge of start relaunches, so a start
    // level held across a whole run cannot retrigger it.
    assign launch = ((state_reg == IDLE) && start) ||
                    ((state_reg == DONE) && start && !start_d_reg);

    // In RUN every edge registers a new vector until the last one is out.
    assign advance = (state_reg == RUN) && !last_reg;

    // The launch edge always registers vector (op 0, idx 0), a corner that
    // needs no LFSR value; the LFSR is reloaded with SEED on that same edge
    // and then steps once for every further vector.
    lfsr64 #(
        .RESET_VALUE (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (launch),
        .en    (advance),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // Vector generator
    always_comb begin
        gen_op   = launch ? 3'd0 : ptr_op_reg;
        gen_idx  = launch ? '0 : ptr_idx_reg;
        gen_ctrl = OP_TABLE[gen_op];
        gen_a    = lfsr_q;
        gen_b    = {lfsr_q[31:0], lfsr_q[63:32]} ^ B_MIX;
        if (gen_idx == IDX_W'(0)) begin
            gen_a = '0;
            gen_b = '0;
        end else if (gen_idx == IDX_W'(1)) begin
            gen_a = '1;
            gen_b = 64'd1;
        end else if (gen_idx == IDX_W'(2)) begin
            gen_a = 64'd1;
            gen_b = '1;
        end else if (gen_idx == IDX_W'(3)) begin
            gen_a = 64'h8000_0000_0000_0000;
            gen_b = 64'h8000_0000_0000_0000;
        end
    end

    // Checker: compares the ALU response to the vector currently on the bus.
    assign expected = alu_golden(alu_ctrl_reg, alu_a_reg, alu_b_reg);
    assign mismatch = (alu_result != expected) || (alu_zero != (expected == '0));

    // FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = RUN;
            RUN:     if (last_reg) state_next = DONE;
            DONE:    if (launch) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: vector registers, pointer, error count and failure capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d_reg     <= 1'b0;
            ptr_op_reg      <= '0;
            ptr_idx_reg     <= '0;
            last_reg        <= 1'b0;
            alu_a_reg       <= '0;
            alu_b_reg       <= '0;
            alu_ctrl_reg    <= '0;
            err_count_reg   <= '0;
            fail_ctrl_reg   <= '0;
            fail_a_reg      <= '0;
            fail_b_reg      <= '0;
            fail_result_reg <= '0;
        end else begin
            start_d_reg <= start;
            if (launch) begin
                alu_a_reg       <= gen_a;
                alu_b_reg       <= gen_b;
                alu_ctrl_reg    <= gen_ctrl;
                ptr_op_reg      <= '0;
                ptr_idx_reg     <= IDX_W'(1);
                last_reg        <= 1'b0;
                err_count_reg   <= '0;
                fail_ctrl_reg   <= '0;
                fail_a_reg      <= '0;
                fail_b_reg      <= '0;
                fail_result_reg <= '0;
            end else if (state_reg == RUN) begin
                if (mismatch) begin
                    if (err_count_reg != 16'hFFFF) begin
                        err_count_reg <= err_count_reg + 16'd1;
                    end
                    if (err_count_reg == 16'd0) begin
                        fail_ctrl_reg   <= alu_ctrl_reg;
                        fail_a_reg      <= alu_a_reg;
                        fail_b_reg      <= alu_b_reg;
                        fail_result_reg <= alu_result;
                    end
                end
                if (!last_reg) begin
                    alu_a_reg    <= gen_a;
                    alu_b_reg    <= gen_b;
                    alu_ctrl_reg <= gen_ctrl;
                    last_reg     <= (ptr_op_reg == OP_MAX) && (ptr_idx_reg == IDX_MAX);
                    if (ptr_idx_reg == IDX_MAX) begin
                        ptr_idx_reg <= '0;
                        ptr_op_reg  <= ptr_op_reg + 3'd1;
                    end else begin
                        ptr_idx_reg <= ptr_idx_reg + IDX_W'(1);
                    end
                end
            end
        end
    end

    assign alu_a       = alu_a_reg;
    assign alu_b       = alu_b_reg;
    assign alu_ctrl    = alu_ctrl_reg;
    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign pass        = (state_reg == DONE) && (err_count_reg == 16'd0);
    assign err_count   = err_count_reg;
    assign fail_ctrl   = fail_ctrl_reg;
    assign fail_a      = fail_a_reg;
    assign fail_b      = fail_b_reg;
    assign fail_result = fail_result_reg;

endmodule

// File: tb/tb_alu_bist.sv
// ---------------------------------------------------------------------------
// tb_alu_bist
// Self-checking bench for alu_bist. A behavioural ALU (with selectable faults)
// answers the BIST. For every run the bench builds its own expected vector
// list into a queue when it drives start, then pops one entry per RUN cycle and
// compares it with alu_a/alu_b/alu_ctrl. End-of-run status is checked against
// counts derived from the same list.
// ---------------------------------------------------------------------------
module tb_alu_bist;

    localparam logic [63:0] SEED = 64'hACE1_0F0F_1234_5678;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [63:0] a;
        logic [63:0] b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with the default vector count
    logic        reset, start;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero, busy, done, pass;
    logic [15:0] err_count;
    logic [3:0]  fail_ctrl;
    logic [63:0] fail_a, fail_b, fail_result;

    // Instance with N_VECTORS=4
    logic        s_reset, s_start;
    logic [63:0] s_alu_a, s_alu_b, s_alu_result;
    logic [3:0]  s_alu_ctrl;
    logic        s_alu_zero, s_busy, s_done, s_pass;
    logic [15:0] s_err_count;
    logic [3:0]  s_fail_ctrl;
    logic [63:0] s_fail_a, s_fail_b, s_fail_result;

    int fault_mode = 0;   // 0 good, 1 ADD returns a+b+1, 2 zero stuck at 0
    bit sel = 1'b0;       // which instance the run task observes
    int n_cmp = 0;
    int n_err = 0;
    vec_t exp_q[$];

    alu_bist dut (
        .clk (clk), .reset (reset), .start (start),
        .alu_a (alu_a), .alu_b (alu_b), .alu_ctrl (alu_ctrl),
        .alu_result (alu_result), .alu_zero (alu_zero),
        .busy (busy), .done (done), .pass (pass), .err_count (err_count),
        .fail_ctrl (fail_ctrl), .fail_a (fail_a), .fail_b (fail_b),
        .fail_result (fail_result)
    );

    alu_bist #(.N_VECTORS (4), .SEED (SEED)) dut_small (
        .clk (clk), .reset (s_reset), .start (s_start),
        .alu_a (s_alu_a), .alu_b (s_alu_b), .alu_ctrl (s_alu_ctrl),
        .alu_result (s_alu_result), .alu_zero (s_alu_zero),
        .busy (s_busy), .done (s_done), .pass (s_pass), .err_count (s_err_count),
        .fail_ctrl (s_fail_ctrl), .fail_a (s_fail_a), .fail_b (s_fail_b),
        .fail_result (s_fail_result)
    );

    function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [63:0] a,
                                            input logic [63:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural ALU seen by the BIST, with fault injection
    function automatic logic [64:0] model_alu(input int mode, input logic [3:0] c,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        z;
        r = ref_alu(c, a, b);
        if (mode == 1 && c == 4'b0010) r = r + 64'd1;
        z = (r == 64'd0);
        if (mode == 2) z = 1'b0;
        return {z, r};
    endfunction

    always_comb begin
        {alu_zero, alu_result}     = model_alu(fault_mode, alu_ctrl, alu_a, alu_b);
        {s_alu_zero, s_alu_result} = model_alu(0, s_alu_ctrl, s_alu_a, s_alu_b);
    end

    logic [63:0] o_a, o_b;
    logic [3:0]  o_ctrl, o_fctrl;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_err;
    logic [63:0] o_fa, o_fb, o_fr;
    assign o_a     = sel ? s_alu_a : alu_a;
    assign o_b     = sel ? s_alu_b : alu_b;
    assign o_ctrl  = sel ? s_alu_ctrl : alu_ctrl;
    assign o_busy  = sel ? s_busy : busy;
    assign o_done  = sel ? s_done : done;
    assign o_pass  = sel ? s_pass : pass;
    assign o_err   = sel ? s_err_count : err_count;
    assign o_fctrl = sel ? s_fail_ctrl : fail_ctrl;
    assign o_fa    = sel ? s_fail_a : fail_a;
    assign o_fb    = sel ? s_fail_b : fail_b;
    assign o_fr    = sel ? s_fail_result : fail_result;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected-run bookkeeping filled while building the vector list
    int          exp_errs;
    logic [3:0]  exp_fctrl;
    logic [63:0] exp_fa, exp_fb, exp_fr;

    task automatic build(input int n, input int mode);
        logic [3:0]  ops [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF};
        logic [63:0] l;
        logic [63:0] g_res;
        logic [64:0] m;
        vec_t        v;
        int          g;
        l = SEED;
        g = 0;
        exp_errs = 0;
        exp_fctrl = '0; exp_fa = '0; exp_fb = '0; exp_fr = '0;
        exp_q.delete();
        for (int o = 0; o < 6; o++) begin
            for (int i = 0; i < n; i++) begin
                v.ctrl = ops[o];
                case (i)
                    0: begin v.a = 64'd0; v.b = 64'd0; end
                    1: begin v.a = {64{1'b1}}; v.b = 64'd1; end
                    2: begin v.a = 64'd1; v.b = {64{1'b1}}; end
                    3: begin v.a = 64'h8000_0000_0000_0000; v.b = 64'h8000_0000_0000_0000; end
                    default: begin
                        v.a = l;
                        v.b = {l[31:0], l[63:32]} ^ 64'hA5A5_A5A5_A5A5_A5A5;
                    end
                endcase
                // The launch vector has no LFSR step behind it; every later one does.
                if (g >= 1) l = {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
                g++;
                exp_q.push_back(v);
                g_res = ref_alu(v.ctrl, v.a, v.b);
                m = model_alu(mode, v.ctrl, v.a, v.b);
                if (m[63:0] != g_res || m[64] != (g_res == 64'd0)) begin
                    if (exp_errs == 0) begin
                        exp_fctrl = v.ctrl; exp_fa = v.a; exp_fb = v.b; exp_fr = m[63:0];
                    end
                    exp_errs++;
                end
            end
        end
    endtask

    task automatic run_check(input bit which, input int n, input int mode, input bit hold);
        vec_t v;
        int   cyc;
        int   errs_before;
        sel = which;
        fault_mode = mode;
        errs_before = n_err;
        @(negedge clk);
        build(n, mode);
        if (which) s_start = 1'b1; else start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            if (which) s_start = 1'b0; else start = 1'b0;
        end
        cyc = 0;
        while (o_busy && cyc < 6 * n + 4) begin
            if (exp_q.size() == 0) begin
                check("vec_extra", 1, 0);
            end else begin
                v = exp_q.pop_front();
                check("vec", {o_ctrl, o_a, o_b}, {v.ctrl, v.a, v.b});
            end
            cyc++;
            @(negedge clk);
        end
        check("busy_cycles", cyc, 6 * n);
        check("done", o_done, 1);
        check("pass", o_pass, exp_errs == 0);
        check("err_count", o_err, exp_errs);
        check("fail_ctrl", o_fctrl, exp_fctrl);
        check("fail_a", o_fa, exp_fa);
        check("fail_b", o_fb, exp_fb);
        check("fail_result", o_fr, exp_fr);
        $display("run N=%0d mode=%0d hold=%0d: busy %0d cycles, err_count %0d, pass %0d, new mismatches %0d",
                 n, mode, hold, cyc, o_err, o_pass, n_err - errs_before);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ab"}, {alu_a, alu_b}, 0);
        check({tag, "_status"}, {alu_ctrl, busy, done, pass, err_count}, 0);
        check({tag, "_fail"}, {fail_ctrl, fail_a, fail_b, fail_result}, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        s_reset = 1'b1; s_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0; s_reset = 1'b0;
        $display("reset released");

        // Good ALU: full run passes
        run_check(0, 256, 0, 0);

        // ADD off by one: every ADD vector fails, first is the all-zero corner
        run_check(0, 256, 1, 0);
        check("add_err_256", err_count, 256);
        check("add_fail_ctrl", fail_ctrl, 4'b0010);
        check("add_fail_result", fail_result, 1);

        // Zero flag stuck low, with start held high throughout
        run_check(0, 256, 2, 1);
        check("zero_fail_ctrl", fail_ctrl, 4'b0000);
        repeat (20) @(negedge clk);
        check("hold_busy", busy, 0);
        check("hold_done", done, 1);
        check("hold_last_ctrl", alu_ctrl, 4'hF);
        $display("start held high for 20 cycles in DONE: busy %0d done %0d", busy, done);

        // Drop start, fresh pulse with a good ALU: counters cleared, same vectors
        start = 1'b0;
        @(negedge clk);
        run_check(0, 256, 0, 0);

        // Reset in the middle of a run
        fault_mode = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        start = 1'b0;
        reset = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        $display("reset during RUN: busy %0d alu_ctrl %0h err_count %0d", busy, alu_ctrl, err_count);
        @(negedge clk);
        reset = 1'b0;
        run_check(0, 256, 0, 0);

        // Small instance: 4 corners per op only
        run_check(1, 4, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
